// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus, filters scan glitches and
// ghosting, and reassembles the displayed hex digits into a frame word.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_strobe,
  output logic                    err,
  output logic [IDX_W-1:0]        err_digit
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

  // Inverse of the hex encoder table; bit 4 flags a recognised pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    unique case (s)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!a[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic [NUM_DIGITS-1:0]   an_p0;
  logic [6:0]              seg_p0;
  logic [CNT_W-1:0]        cnt_p0;
  state_t                  state;
  logic [4*NUM_DIGITS-1:0] stage_nib;
  logic [NUM_DIGITS-1:0]   stage_blank;
  logic [NUM_DIGITS-1:0]   seen;

  logic                    legal;
  logic                    same;
  logic                    capture;
  logic                    blank;
  logic                    bad;
  logic [4:0]              dec;
  logic [IDX_W-1:0]        digit;
  logic [4*NUM_DIGITS-1:0] nib_next;
  logic [NUM_DIGITS-1:0]   blank_next;
  logic [NUM_DIGITS-1:0]   seen_next;

  assign legal   = ($countones(~an) == 1);
  assign same    = (an == an_p0) && (seg == seg_p0);
  // Fires on the STABLE_CYCLES-th consecutive identical legal sample.
  assign capture = (state == SETTLE) && legal && same && (cnt_p0 == CNT_FIRE);
  assign digit   = low_index(an);
  assign dec     = decode_seg(seg);
  assign blank   = (seg == 7'b1111111);
  assign bad     = !dec[4] && !blank;

  always_comb begin
    nib_next   = stage_nib;
    blank_next = stage_blank;
    seen_next  = seen;
    nib_next[{digit, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
    blank_next[digit]             = blank;
    seen_next[digit]              = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_p0        <= '0;
      seg_p0       <= '0;
      cnt_p0       <= '0;
      state        <= WAIT;
      stage_nib    <= '0;
      stage_blank  <= '0;
      seen         <= '0;
      value        <= '0;
      blank_mask   <= '0;
      frame_strobe <= 1'b0;
      err          <= 1'b0;
      err_digit    <= '0;
    end else begin
      // Stage 0: sample register and stability counter
      an_p0  <= an;
      seg_p0 <= seg;
      if (!same || !legal)
        cnt_p0 <= '0;
      else if (cnt_p0 != CNT_MAX)
        cnt_p0 <= cnt_p0 + 1'b1;

      unique case (state)
        WAIT:    if (legal) state <= SETTLE;
        SETTLE:  if (!legal) state <= WAIT;
                 else if (capture) state <= HOLD;
        HOLD:    if (!same) state <= legal ? SETTLE : WAIT;
        default: state <= WAIT;
      endcase

      // Stage 1: capture into staging and frame assembly
      frame_strobe <= 1'b0;
      if (capture) begin
        stage_nib   <= nib_next;
        stage_blank <= blank_next;
        if (&seen_next) begin
          value        <= nib_next;
          blank_mask   <= blank_next;
          frame_strobe <= 1'b1;
          seen         <= '0;
        end else begin
          seen <= seen_next;
        end
      end

      if (capture && bad) begin
        err       <= 1'b1;
        err_digit <= digit;
      end else if (clr_err) begin
        err       <= 1'b0;
        err_digit <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: directed scan scenarios plus random bus traffic, all
// compared cycle by cycle against a run-length based reference model.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic          clk;
  logic          rst;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          clr_err;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank_mask;
  logic          frame_strobe;
  logic          err;
  logic [1:0]    err_digit;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .clr_err(clr_err),
    .value(value), .blank_mask(blank_mask), .frame_strobe(frame_strobe),
    .err(err), .err_digit(err_digit));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_strobe = 0;

  // Reference model state
  int            run;
  logic [ND-1:0] prev_an;
  logic [6:0]    prev_seg;
  logic [3:0]    m_nib [ND];
  logic [ND-1:0] m_sblank;
  logic [ND-1:0] m_seen;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0] m_blank;
  logic          m_strobe;
  logic          m_err;
  logic [1:0]    m_errd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_decode(input logic [6:0] s, output logic [3:0] nib,
                              output logic blk, output logic bad);
    nib = 4'h0;
    blk = (s == 7'b1111111);
    bad = !blk;
    for (int i = 0; i < 16; i++)
      if (SEG_TAB[i] == s) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  endtask

  task automatic model_edge(input logic [ND-1:0] a, input logic [6:0] s,
                            input logic c, input logic r);
    logic cap, bad, blk;
    logic [3:0] nib;
    int d;
    if (r) begin
      run = 0; prev_an = '0; prev_seg = '0;
      for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
      m_sblank = '0; m_seen = '0; m_value = '0; m_blank = '0;
      m_strobe = 1'b0; m_err = 1'b0; m_errd = '0;
      return;
    end
    if (a == prev_an && s == prev_seg) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    prev_an = a; prev_seg = s;
    m_strobe = 1'b0;
    cap = ($countones(~a) == 1) && (run == S);
    bad = 1'b0;
    if (cap) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) d = i;
      model_decode(s, nib, blk, bad);
      m_nib[d] = nib;
      m_sblank[d] = blk;
      m_seen[d] = 1'b1;
      if (m_seen == '1) begin
        for (int i = 0; i < ND; i++) m_value[4*i +: 4] = m_nib[i];
        m_blank  = m_sblank;
        m_strobe = 1'b1;
        m_seen   = '0;
      end
      if (bad) begin
        m_err  = 1'b1;
        m_errd = 2'(d);
      end
    end
    if (!(cap && bad) && c) begin
      m_err  = 1'b0;
      m_errd = '0;
    end
  endtask

  task automatic step(input logic [ND-1:0] a, input logic [6:0] s,
                      input logic c, input logic r);
    an = a; seg = s; clr_err = c; rst = r;
    @(posedge clk);
    model_edge(a, s, c, r);
    #1;
    if (frame_strobe === 1'b1) n_strobe++;
    check_eq("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
    check_eq("value", 32'(value), 32'(m_value));
    check_eq("blank_mask", 32'(blank_mask), 32'(m_blank));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("err_digit", 32'(err_digit), 32'(m_errd));
  endtask

  function automatic logic [27:0] hex4(input int h3, input int h2, input int h1, input int h0);
    return {SEG_TAB[h3], SEG_TAB[h2], SEG_TAB[h1], SEG_TAB[h0]};
  endfunction

  // Scans digits 0..ndig-1 once; clr_err is pulsed on cycle clr_cyc of digit clr_dig.
  task automatic scan_round(input logic [27:0] d, input int ndig, input int dwell,
                            input int ghost, input int clr_dig, input int clr_cyc);
    logic [ND-1:0] a;
    for (int k = 0; k < ndig; k++) begin
      a = ~(4'b0001 << k);
      for (int j = 0; j < dwell; j++)
        step(a, d[7*k +: 7], (k == clr_dig && j == clr_cyc), 1'b0);
      for (int g = 0; g < ghost; g++)
        step(4'b1110, 7'b0000000, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [27:0] pat;
    logic [ND-1:0] ra;
    logic [6:0] rs;
    int dw;

    an = '1; seg = '1; clr_err = 1'b0; rst = 1'b1;
    step('1, '1, 1'b0, 1'b1);
    step('1, '1, 1'b0, 1'b1);
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_blank", 32'(blank_mask), 32'h0);
    check_eq("rst_strobe", 32'(frame_strobe), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_err_digit", 32'(err_digit), 32'h0);

    // Plain round-robin scan of 1A3F, two rounds
    pat = hex4(1, 10, 3, 15);
    n_strobe = 0;
    scan_round(pat, 4, 8, 0, -1, -1);
    scan_round(pat, 4, 8, 0, -1, -1);
    check_eq("scan_value", 32'(value), 32'h1A3F);
    check_eq("scan_blank", 32'(blank_mask), 32'h0);
    check_eq("scan_strobes", 32'(n_strobe), 32'd2);
    check_eq("scan_err", 32'(err), 32'h0);

    // Same scan with short ghosts between digits
    step(4'b1111, 7'b1111111, 1'b0, 1'b1);
    n_strobe = 0;
    scan_round(pat, 4, 8, 2, -1, -1);
    check_eq("ghost_value", 32'(value), 32'h1A3F);
    check_eq("ghost_strobes", 32'(n_strobe), 32'd1);

    // Blank digit 2
    n_strobe = 0;
    pat = {SEG_TAB[0], 7'b1111111, SEG_TAB[0], SEG_TAB[0]};
    scan_round(pat, 4, 6, 0, -1, -1);
    check_eq("blank_value", 32'(value), 32'h0000);
    check_eq("blank_mask", 32'(blank_mask), 32'h4);
    check_eq("blank_strobes", 32'(n_strobe), 32'd1);

    // Unrecognised pattern on digit 1
    n_strobe = 0;
    pat = {SEG_TAB[0], SEG_TAB[0], 7'b0101010, SEG_TAB[0]};
    scan_round(pat, 4, 6, 0, -1, -1);
    check_eq("bad_err", 32'(err), 32'h1);
    check_eq("bad_err_digit", 32'(err_digit), 32'h1);
    check_eq("bad_strobes", 32'(n_strobe), 32'd1);
    scan_round(pat, 4, 6, 0, 1, S - 1);
    check_eq("clr_vs_bad_err", 32'(err), 32'h1);
    pat = {SEG_TAB[0], SEG_TAB[0], SEG_TAB[1], SEG_TAB[0]};
    scan_round(pat, 4, 6, 0, -1, -1);
    check_eq("fixed_value", 32'(value), 32'h0010);
    check_eq("fixed_err_held", 32'(err), 32'h1);
    step(4'b1111, 7'b1111111, 1'b1, 1'b0);
    check_eq("clr_err", 32'(err), 32'h0);
    check_eq("clr_err_digit", 32'(err_digit), 32'h0);

    // Illegal anode patterns held
    n_strobe = 0;
    for (int i = 0; i < 20; i++) step(4'b1100, SEG_TAB[8], 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b1111, SEG_TAB[8], 1'b0, 1'b0);
    check_eq("illegal_strobes", 32'(n_strobe), 32'd0);
    check_eq("illegal_value", 32'(value), 32'h0010);

    // Reset after a partial frame, then a clean frame
    scan_round(hex4(1, 2, 3, 4), 3, 6, 0, -1, -1);
    step(4'b1111, 7'b1111111, 1'b0, 1'b1);
    check_eq("midrst_value", 32'(value), 32'h0);
    check_eq("midrst_blank", 32'(blank_mask), 32'h0);
    check_eq("midrst_err", 32'(err), 32'h0);
    n_strobe = 0;
    scan_round(hex4(0, 0, 4, 2), 4, 6, 0, -1, -1);
    check_eq("post_rst_value", 32'(value), 32'h0042);
    check_eq("post_rst_strobes", 32'(n_strobe), 32'd1);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 8) ra = ~(4'b0001 << $urandom_range(0, ND - 1));
      else ra = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       rs = 7'b1111111;
        1, 2:    rs = 7'($urandom);
        default: rs = SEG_TAB[$urandom_range(0, 15)];
      endcase
      dw = $urandom_range(1, 10);
      for (int j = 0; j < dw; j++)
        step(ra, rs, ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
